// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    // REQ: may issue a request; WAIT: one fetch in flight and wanted;
    // DRAIN: one fetch in flight whose data must be thrown away.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem read, registered IF/ID output.
// Latency: request accepted in t, response in t+k -> fetch_valid in t+k+1.
// Backpressure: no request issued unless the output register is free or being consumed.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    output logic [INSTR_WIDTH-1:0] fetch_instr
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~{{(PC_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [PC_WIDTH-1:0]   pc;
    logic                  req_fire;
    logic                  load;

    assign imem_req_addr = pc;

    // Request only when the output register will be free by the time data lands,
    // so the response never needs a holding buffer. Suppressed during a redirect.
    always_comb begin
        imem_req_valid = rst_n && (state == REQ) && !redirect_valid
                         && (!fetch_valid || fetch_ready);
        req_fire       = imem_req_valid && imem_req_ready;
        load           = (state == WAIT) && imem_resp_valid && !redirect_valid;
    end

    // Next-state: redirect overrides everything; any response in flight is dropped.
    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // PC: redirect target (word aligned) wins, else advance when an instruction is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (load) begin
            pc <= pc + STEP;
        end
    end

    // IF/ID output register: redirect flushes, load overwrites, consume empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else if (redirect_valid) begin
            fetch_valid <= 1'b0;
        end else if (load) begin
            fetch_valid <= 1'b1;
            fetch_pc    <= pc;
            fetch_instr <= imem_resp_data;
        end else if (fetch_valid && fetch_ready) begin
            fetch_valid <= 1'b0;
        end
    end

    // A response with nothing outstanding is a memory protocol violation; it is ignored.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !((state == REQ) && imem_resp_valid))
        else $warning("if_fetch_unit: imem response with no fetch outstanding, ignored");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit against an instruction-stream reference model.
// Latency: n/a.
// Backpressure: randomised on both imem_req_ready and fetch_ready.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;

    // second instance to exercise PC wrap-around from the top of the address space
    logic        w_req_valid;
    logic        w_req_ready;
    logic [63:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_redirect;
    logic [63:0] w_redirect_pc;
    logic        w_fvalid;
    logic        w_fready;
    logic [63:0] w_fpc;
    logic [31:0] w_finstr;

    if_fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'h1000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
    );

    if_fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .fetch_valid(w_fvalid), .fetch_ready(w_fready),
        .fetch_pc(w_fpc), .fetch_instr(w_finstr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'hA5A5_0F0F;
    endfunction

    // stimulus knobs
    int rdy_pct   = 100;
    int fr_pct    = 100;
    int redir_pct = 0;
    int lat_min   = 0;
    int lat_max   = 0;
    logic        redir_force = 1'b0;
    logic [63:0] redir_tgt   = '0;
    logic        rst_req     = 1'b0;
    logic        late_resp   = 1'b0;

    // memory model state
    logic        pend      = 1'b0;
    logic [63:0] pend_addr = '0;
    int          wcnt      = 0;

    // reference model: address of the next instruction IF/ID should receive
    logic [63:0] exp_pc = 64'h1000;
    int          cyc    = 0;
    int          n_cons = 0;
    logic [63:0] cons_pc[$];
    int          cons_cyc[$];

    // per-cycle samples
    logic        s_reqv, s_fire, s_fvalid;
    logic [63:0] s_addr, s_fpc;
    logic [31:0] s_finstr;

    // One clock cycle: drive inputs after the falling edge, sample just after, update models.
    task automatic step();
        logic lr;
        logic mem_resp;
        @(negedge clk);
        cyc++;
        rst_n           = rst_req;
        lr              = late_resp;
        late_resp       = 1'b0;
        mem_resp        = pend && (wcnt == 0);
        imem_req_ready  = ($urandom_range(99) < rdy_pct);
        imem_resp_valid = mem_resp || lr;
        imem_resp_data  = mem_resp ? mem_word(pend_addr) : $urandom;
        fetch_ready     = ($urandom_range(99) < fr_pct);
        if (redir_force) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_force    = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = {32'h0, $urandom & 32'h0000_FFFF};
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
        #1;
        s_reqv   = imem_req_valid;
        s_addr   = imem_req_addr;
        s_fire   = imem_req_valid && imem_req_ready;
        s_fvalid = fetch_valid;
        s_fpc    = fetch_pc;
        s_finstr = fetch_instr;
        if (!rst_n) begin
            pend   = 1'b0;
            exp_pc = 64'h1000;
            check_eq("reset_req_valid", {63'h0, s_reqv}, 64'h0);
        end else begin
            check_eq("req_addr_align", {62'h0, s_addr[1:0]}, 64'h0);
            if (mem_resp) begin
                pend = 1'b0;
            end else if (pend && wcnt != 0) begin
                wcnt--;
            end
            if (s_fire) begin
                check_eq("one_outstanding", {63'h0, pend}, 64'h0);
                pend      = 1'b1;
                pend_addr = s_addr;
                wcnt      = $urandom_range(lat_max, lat_min);
            end
            if (s_fvalid && !fetch_ready) begin
                check_eq("bp_req_valid", {63'h0, s_reqv}, 64'h0);
            end
            if (s_fvalid && fetch_ready) begin
                check_eq("fetch_pc", s_fpc, exp_pc);
                check_eq("fetch_instr", {32'h0, s_finstr}, {32'h0, mem_word(exp_pc)});
                cons_pc.push_back(s_fpc);
                cons_cyc.push_back(cyc);
                n_cons++;
                exp_pc = exp_pc + 64'd4;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~64'h3;
            end
        end
    endtask

    // wrap instance: always-ready memory with one-cycle latency, fetch_ready tied high
    logic        w_pend = 1'b0;
    logic [63:0] w_pend_addr = '0;
    logic [63:0] w_pc_q[$];
    logic [31:0] w_in_q[$];

    initial begin
        w_req_ready   = 1'b1;
        w_fready      = 1'b1;
        w_resp_valid  = 1'b0;
        w_resp_data   = '0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        forever begin
            @(negedge clk);
            w_resp_valid = w_pend;
            w_resp_data  = mem_word(w_pend_addr);
            #1;
            if (!rst_n) begin
                w_pend = 1'b0;
            end else begin
                w_pend      = w_req_valid;
                w_pend_addr = w_req_addr;
                if (w_fvalid && w_pc_q.size() < 2) begin
                    w_pc_q.push_back(w_fpc);
                    w_in_q.push_back(w_finstr);
                end
            end
        end
    end

    initial begin
        int  base;
        int  tfire;
        int  c0;
        bit  found;
        logic [63:0] rec_pc;
        logic [31:0] rec_in;

        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        fetch_ready     = 1'b0;

        // reset state
        repeat (3) step();
        check_eq("rst_fetch_valid", {63'h0, fetch_valid}, 64'h0);
        check_eq("rst_fetch_pc", fetch_pc, 64'h0);
        check_eq("rst_fetch_instr", {32'h0, fetch_instr}, 64'h0);
        check_eq("rst_req_addr", imem_req_addr, 64'h1000);

        // sequential fetch, single-cycle memory, IF/ID always ready
        cons_pc.delete();
        cons_cyc.delete();
        rst_req = 1'b1;
        base = cyc;
        step();
        check_eq("first_req_valid", {63'h0, s_reqv}, 64'h1);
        check_eq("first_req_addr", s_addr, 64'h1000);
        repeat (7) step();
        check_eq("seq_count", {63'h0, (cons_pc.size() >= 3)}, 64'h1);
        if (cons_pc.size() >= 3) begin
            check_eq("seq_pc0", cons_pc[0], 64'h1000);
            check_eq("seq_pc1", cons_pc[1], 64'h1004);
            check_eq("seq_pc2", cons_pc[2], 64'h1008);
            check_eq("seq_cyc0", 64'(cons_cyc[0] - base), 64'd3);
            check_eq("seq_cyc1", 64'(cons_cyc[1] - base), 64'd5);
            check_eq("seq_cyc2", 64'(cons_cyc[2] - base), 64'd7);
        end

        // backpressure: hold IF/ID off for 5 cycles
        fr_pct = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fvalid) found = 1;
        end
        check_eq("bp_wait_valid", {63'h0, found}, 64'h1);
        rec_pc = s_fpc;
        rec_in = s_finstr;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_hold_valid", {63'h0, s_fvalid}, 64'h1);
            check_eq("bp_hold_req", {63'h0, s_reqv}, 64'h0);
            check_eq("bp_hold_pc", s_fpc, rec_pc);
            check_eq("bp_hold_instr", {32'h0, s_finstr}, {32'h0, rec_in});
        end
        fr_pct = 100;
        step();
        check_eq("bp_release_req", {63'h0, s_reqv}, 64'h1);

        // redirect while WAIT, memory answers three cycles after accept
        lat_min = 2;
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fire) found = 1;
        end
        check_eq("rw_fire_seen", {63'h0, found}, 64'h1);
        tfire = cyc;
        redir_force = 1'b1;
        redir_tgt   = 64'h2002;
        step();
        step();
        check_eq("rw_flushed", {63'h0, s_fvalid}, 64'h0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_reqv) found = 1;
        end
        check_eq("rw_req_seen", {63'h0, found}, 64'h1);
        check_eq("rw_req_addr", s_addr, 64'h2000);
        check_eq("rw_req_cycle", 64'(cyc - tfire), 64'd4);

        // redirect in the same cycle as the response
        lat_min = 0;
        lat_max = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fire) found = 1;
        end
        check_eq("rc_fire_seen", {63'h0, found}, 64'h1);
        redir_force = 1'b1;
        redir_tgt   = 64'h3000;
        step();
        step();
        check_eq("rc_req_valid", {63'h0, s_reqv}, 64'h1);
        check_eq("rc_req_addr", s_addr, 64'h3000);
        check_eq("rc_fetch_valid", {63'h0, s_fvalid}, 64'h0);
        repeat (4) step();

        // reset mid-WAIT; the stale response arrives just after release
        lat_min = 2;
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fire) found = 1;
        end
        check_eq("rst_fire_seen", {63'h0, found}, 64'h1);
        step();
        rst_req = 1'b0;
        repeat (2) step();
        lat_min   = 0;
        lat_max   = 0;
        rst_req   = 1'b1;
        late_resp = 1'b1;
        step();
        check_eq("rst_req_after", {63'h0, s_reqv}, 64'h1);
        check_eq("rst_addr_after", s_addr, 64'h1000);
        step();
        check_eq("rst_late_ignored", {63'h0, s_fvalid}, 64'h0);
        step();
        check_eq("rst_first_valid", {63'h0, s_fvalid}, 64'h1);
        check_eq("rst_first_pc", s_fpc, 64'h1000);

        // randomised traffic
        rdy_pct   = 60;
        fr_pct    = 70;
        redir_pct = 5;
        lat_min   = 0;
        lat_max   = 3;
        c0 = n_cons;
        repeat (3000) step();
        check_eq("random_progress", {63'h0, ((n_cons - c0) > 200)}, 64'h1);

        // wrap instance results
        check_eq("wrap_count", 64'(w_pc_q.size()), 64'd2);
        if (w_pc_q.size() == 2) begin
            check_eq("wrap_pc0", w_pc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check_eq("wrap_pc1", w_pc_q[1], 64'h0);
            check_eq("wrap_in0", {32'h0, w_in_q[0]}, {32'h0, mem_word(64'hFFFF_FFFF_FFFF_FFFC)});
            check_eq("wrap_in1", {32'h0, w_in_q[1]}, {32'h0, mem_word(64'h0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage pipeline. Owns the program counter and issues one instruction-memory read at a time over a valid/ready request channel. It presents each fetched instruction and its PC to the IF/ID pipeline register through a valid/ready handshake. It also accepts branch/jump redirects from later stages and discards any stale in-flight fetch.

## Interface
Parameters:
- PC_WIDTH, 64, width of the PC and memory address
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be zero

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  PC_WIDTH  word-aligned read address
- imem_resp_valid  input  1  read data valid (no ready; always accepted)
- imem_resp_data  input  32  instruction word
- redirect_valid  input  1  single-cycle redirect from EX/branch unit
- redirect_pc  input  PC_WIDTH  redirect target; bits [1:0] ignored, forced to 0
- fetch_valid  output  1  fetch_pc/fetch_instr valid for IF/ID
- fetch_ready  input  1  IF/ID accepts this cycle
- fetch_pc  output  PC_WIDTH  PC of presented instruction
- fetch_instr  output  32  presented instruction

## Operation
- Registers:
  - pc: next address to fetch.
  - state: one of REQ, WAIT, DRAIN.
  - Output register: fetch_valid, fetch_pc, fetch_instr.
- Reset values: pc=RESET_PC, state=REQ, fetch_valid=0, fetch_pc=0, fetch_instr=0. imem_req_valid=0 while rst_n is low.
- At most one memory request outstanding at any time.
- imem_req_addr = pc at all times.
- imem_req_valid = (state==REQ) && !redirect_valid && (!fetch_valid || fetch_ready).
  - A request is issued only when the output register will be empty when the response lands, so no response buffer exists.
- REQ:
  - On request handshake (req_valid && req_ready), go to WAIT.
  - Otherwise hold state; req_valid may drop.
- WAIT:
  - On imem_resp_valid: load the output register (fetch_valid=1, fetch_pc=pc, fetch_instr=data), set pc=pc+4, go to REQ.
- DRAIN:
  - On imem_resp_valid: discard the data, go to REQ.
- Redirect has top priority in every state:
  - pc=redirect_pc & ~3 and fetch_valid=0 on the next edge.
  - REQ: no request is issued that cycle; state stays REQ.
  - WAIT, no response that cycle: go to DRAIN.
  - WAIT, response in the same cycle: discard the response; go to REQ.
  - DRAIN, no response: stay DRAIN with the new pc.
  - DRAIN, response in the same cycle: discard; go to REQ.
- Output handshake: when fetch_valid && fetch_ready and no new load occurs, clear fetch_valid. A load in the same cycle as a consume overwrites the register and keeps it valid.
- Arithmetic: pc+4 is modulo 2^PC_WIDTH; all-ones-minus-3 wraps to 0.
- imem_resp_valid in REQ is a protocol violation. Ignore it and flag it with an assertion.

## Timing
- First request is visible in the first cycle after rst_n deasserts.
- Request accepted in cycle t with response in cycle t+k (k≥1): fetch_valid=1 from cycle t+k+1, next request asserted in cycle t+k+1.
- Peak throughput is one instruction per 2 cycles, with single-cycle memory and fetch_ready held at 1.
- Redirect asserted in cycle t:
  - fetch_valid=0 and pc=target in cycle t+1.
  - With no fetch outstanding, the request to the target appears in cycle t+1.
- Outputs are all registered or decoded from state; no combinational path from fetch_ready to fetch_* data. The only such path is fetch_ready→imem_req_valid.
- Asynchronous reset mid-WAIT abandons the fetch. A late response arriving after reset, in REQ, is ignored.

## Structure
- Shared package if_pkg:
  - state enum {REQ, WAIT, DRAIN}
  - INSTR_WIDTH=32
  - PC_STEP=4
- Single module; no sub-module needed. The output register may optionally be factored as if_out_reg; the default is inline.

## Test plan
- Sequential fetch: RESET_PC=0x1000, memory responds 1 cycle after accept, fetch_ready=1 → fetch_pc 0x1000, 0x1004, 0x1008 on every second cycle; instructions match memory contents.
- Backpressure: fetch_ready=0 for 5 cycles while fetch_valid=1 → imem_req_valid stays 0 and fetch_pc/fetch_instr stay stable. Raising ready → consume, and the next request is issued in the same cycle.
- Redirect in WAIT to 0x2002: memory responds 3 cycles later → response dropped, fetch_valid never shows the old PC, next request addr=0x2000.
- Redirect coincident with response → response discarded, state REQ, next request at the target in the following cycle.
- Reset asserted mid-WAIT, response arrives after deassert → ignored; first fetch_pc=RESET_PC.
- Wrap: RESET_PC=2^64−4 → fetch_pc 0xFFFF_FFFF_FFFF_FFFC then 0x0.
